seg_scan_driver: RTL
====================

# seg_scan_driver

Time-multiplexed scan driver for the eight-digit seven-segment display. It sits directly downstream of the per-mode display formatters and consumes their eight per-digit segment patterns (data7..data0). It drives the board's two shared segment buses and eight digit enables. Each frame it latches a coherent snapshot of the patterns so a digit never shows a mix of old and new content. It also applies per-digit blanking, per-digit blinking and an anti-ghosting guard interval.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 1000, digit-slot rate. Slot length DIV = CLK_HZ/SCAN_HZ cycles; DIV must be ≥ 2.
- GUARD, 2, cycles at the start of each slot with all digit enables off. Must satisfy 0 ≤ GUARD < DIV.
- BLINK_FRAMES, 63, number of frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scan; 0 = display dark and scan frozen.
- data7..data0  in  8 each  segment pattern per digit (bit 7 = DP, active-high), from the display formatters.
- blank_mask  in  8  bit i = 1 forces digit i dark.
- blink_mask  in  8  bit i = 1 makes digit i dark during the blink off-phase.
- an  out  8  digit enables, active-high, one-hot or zero; bit i = digit i.
- seg_hi  out  8  segment bus shared by digits 7..4.
- seg_lo  out  8  segment bus shared by digits 3..0.
- frame_tick  out  1  one-cycle pulse when a new snapshot is loaded.

## Operation
- Slot counter pc runs 0..DIV-1 while enable = 1. When pc = DIV-1 it wraps to 0 and the scan index idx advances: 0,1,…,7,0.
- Shadow registers hold the snapshot: sh7..sh0, sh_blank, sh_blink. All eight shadow registers load together in one cycle.
- A snapshot loads:
  - on the first enabled cycle after reset (a load_pending flag is set by reset and cleared by that load);
  - on every idx wrap from 7 to 0.
- frame_tick = 1 in the cycle after each load.
- Blink: frame counter fc runs 0..BLINK_FRAMES-1 and advances on each idx 7→0 wrap. When fc wraps, blink_phase toggles. blink_phase = 1 is the off-phase.
- Digit i is visible when all of the following hold:
  - i = idx;
  - pc ≥ GUARD;
  - sh_blank[i] = 0;
  - not (sh_blink[i] = 1 and blink_phase = 1).
- Output decode (registered):
  - an = one-hot(idx) if the digit is visible, else 0.
  - If idx ≥ 4: seg_hi = sh[idx] when visible, else 0; seg_lo = 0.
  - If idx < 4: seg_lo = sh[idx] when visible, else 0; seg_hi = 0.
- Data inputs are sampled only at snapshot loads. Changes at any other time have no effect until the next frame.
- enable = 0:
  - an, seg_hi, seg_lo and frame_tick are 0 from the next cycle;
  - pc resets to 0;
  - idx, fc, blink_phase and the shadow registers hold;
  - load_pending is set, so re-enabling triggers a fresh snapshot.

## Timing
- Reset (asynchronous, active-low) clears: pc, idx, fc, blink_phase, all shadow registers, an, seg_hi, seg_lo and frame_tick to 0. It sets load_pending = 1.
- Latency: outputs reflect the state (pc, idx, shadow, phase) of the previous cycle, i.e. one register stage.
- A snapshot load and the idx 7→0 wrap happen on the same edge. Digit 0 of the new frame therefore already shows the new snapshot.
- The slot for digit i lasts DIV cycles. an is 0 for the first GUARD cycles of the slot, then one-hot for DIV-GUARD cycles.
- Frame period = 8·DIV cycles. Blink half-period = BLINK_FRAMES·8·DIV cycles.
- enable falling in the same cycle as a wrap: the wrap is discarded; idx holds its pre-wrap value.
- Reset asserted mid-slot: outputs go to 0 immediately (asynchronous), with no partial-slot residue after release.

## Test plan
All scenarios use CLK_HZ=8, SCAN_HZ=2 (DIV=4), GUARD=1, BLINK_FRAMES=2.
- Reset release with enable=1, data0=8'h3F, data4=8'h06:
  - frame_tick pulses once;
  - an sequence per slot is 0,01,01,01, then 0,02,02,02, and so on;
  - seg_lo=3F while an=01; seg_hi=06 while an=10; the inactive bus stays 00.
- Change data2 from 8'h5B to 8'h4F during slot 5: the display keeps 5B for the rest of the frame; 4F appears in slot 2 of the next frame.
- blank_mask=8'h81: an never equals 01 or 80; those slots stay dark for all 4 cycles.
- blink_mask=8'h02: digit 1 is lit for 2 frames (64 cycles), dark for 2 frames, and so on; the other digits are unaffected.
- enable=0 asserted mid-slot 3:
  - an/seg go 0 next cycle;
  - on re-enable, frame_tick pulses, scanning resumes at idx 3 with pc=0 and shows freshly latched data.
- Reset asserted during slot 6 with an=40: an, seg_hi, seg_lo and frame_tick go 0 asynchronously; after release the scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Eight-digit seven-segment scan driver. Each frame it latches a coherent
// snapshot of the digit patterns and masks. It then scans one digit per slot,
// with a dark guard interval at the start of each slot and per-digit
// blank/blink gating. All outputs are registered.
module seg_scan_driver #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data7,
  input  logic [7:0] data6,
  input  logic [7:0] data5,
  input  logic [7:0] data4,
  input  logic [7:0] data3,
  input  logic [7:0] data2,
  input  logic [7:0] data1,
  input  logic [7:0] data0,
  input  logic [7:0] blank_mask,
  input  logic [7:0] blink_mask,
  output logic [7:0] an,
  output logic [7:0] seg_hi,
  output logic [7:0] seg_lo,
  output logic       frame_tick
);

  localparam int unsigned Div = CLK_HZ / SCAN_HZ;
  localparam int unsigned PcW = $clog2(Div);
  localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PcW-1:0] PcLast  = PcW'(Div - 1);
  localparam logic [PcW-1:0] PcGuard = PcW'(GUARD);
  localparam logic [FcW-1:0] FcLast  = FcW'(BLINK_FRAMES - 1);

  logic [PcW-1:0] pc_q, pc_d;
  logic [2:0]     idx_q, idx_d;
  logic [FcW-1:0] fc_q, fc_d;
  logic           phase_q, phase_d;
  logic           pend_q, pend_d;
  logic [7:0]     sh_q [8];
  logic [7:0]     sh_d [8];
  logic [7:0]     blank_q, blank_d;
  logic [7:0]     blink_q, blink_d;
  logic [7:0]     an_q, an_d;
  logic [7:0]     hi_q, hi_d;
  logic [7:0]     lo_q, lo_d;
  logic           ft_q, ft_d;

  logic [7:0] data_in [8];
  logic       slot_end, frame_end, load, visible;

  assign data_in[0] = data0;
  assign data_in[1] = data1;
  assign data_in[2] = data2;
  assign data_in[3] = data3;
  assign data_in[4] = data4;
  assign data_in[5] = data5;
  assign data_in[6] = data6;
  assign data_in[7] = data7;

  assign slot_end  = (pc_q == PcLast);
  assign frame_end = slot_end && (idx_q == 3'd7);
  // The snapshot load and the 7->0 wrap share an edge, so digit 0 of the
  // new frame is decoded from the fresh snapshot.
  assign load      = pend_q || frame_end;
  assign visible   = (pc_q >= PcGuard) && !blank_q[idx_q] && !(blink_q[idx_q] && phase_q);

  // Next-state for scan position, snapshot, blink phase and output decode.
  always_comb begin
    pc_d    = pc_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    sh_d    = sh_q;
    blank_d = blank_q;
    blink_d = blink_q;
    an_d    = 8'h00;
    hi_d    = 8'h00;
    lo_d    = 8'h00;
    ft_d    = 1'b0;
    if (enable) begin
      if (visible) begin
        an_d = 8'h01 << idx_q;
        if (idx_q[2]) hi_d = sh_q[idx_q];
        else          lo_d = sh_q[idx_q];
      end
      ft_d = load;
      if (load) begin
        sh_d    = data_in;
        blank_d = blank_mask;
        blink_d = blink_mask;
        pend_d  = 1'b0;
      end
      if (slot_end) begin
        pc_d  = '0;
        idx_d = idx_q + 3'd1;
      end else begin
        pc_d = pc_q + PcW'(1);
      end
      if (frame_end) begin
        if (fc_q == FcLast) begin
          fc_d    = '0;
          phase_d = ~phase_q;
        end else begin
          fc_d = fc_q + FcW'(1);
        end
      end
    end else begin
      // Freeze the scan; a pending load refreshes the snapshot on re-enable.
      pc_d   = '0;
      pend_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      idx_q   <= 3'd0;
      fc_q    <= '0;
      phase_q <= 1'b0;
      pend_q  <= 1'b1;
      sh_q    <= '{default: 8'h00};
      blank_q <= 8'h00;
      blink_q <= 8'h00;
      an_q    <= 8'h00;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      ft_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      sh_q    <= sh_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      an_q    <= an_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ft_q    <= ft_d;
    end
  end

  assign an         = an_q;
  assign seg_hi     = hi_q;
  assign seg_lo     = lo_q;
  assign frame_tick = ft_q;

endmodule
